tone_sample_gen: RTL and testbench

TONE_SAMPLE_GEN -- requirements
Module: tone_sample_gen

---
 rtl/tone_sample_gen_pkg.sv | 17 +
 rtl/tone_sample_gen_osc.sv | 33 +++
 rtl/tone_sample_gen.sv | 104 ++++++++++
 tb/tb_tone_sample_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_sample_gen_pkg.sv
// Shared widths, envelope-state encoding and default ceiling for the tone
// sample generator and its oscillator.
package tone_sample_gen_pkg;

    localparam int AMP_W           = 15;
    localparam int DIV_W           = 20;
    localparam int SAMPLE_W        = 16;
    localparam int AMP_MAX_DEFAULT = 32767;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_e;

endpackage

// File: rtl/tone_sample_gen_osc.sv
// Free-running square-wave oscillator: phase toggles every note_div clocks,
// held at zero while note_div is zero.
module square_osc
    import tone_sample_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] note_div,
    output logic             phase
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;

    // The >= compare makes a newly lowered note_div wrap at once instead of overrunning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (note_div == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt >= note_div - DIV_W'(1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + DIV_W'(1);
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/tone_sample_gen.sv
// Tone sample generator: square oscillator shaped by an attack/sustain/release
// envelope, scaled by volume and registered as a stereo frame per sample_tick.
module tone_sample_gen
    import tone_sample_gen_pkg::*;
#(
    parameter int ATTACK_STEP  = 4096,
    parameter int RELEASE_STEP = 2048,
    parameter int AMP_MAX      = AMP_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic             key_on,
    input  logic [DIV_W-1:0] note_div,
    input  logic [3:0]       vol,
    output logic [31:0]      audio_out,
    output logic             active,
    output logic [1:0]       env_state
);

    localparam int SUM_W = AMP_W + 2;
    localparam logic [SUM_W-1:0] ATT_V = SUM_W'(ATTACK_STEP);
    localparam logic [SUM_W-1:0] REL_V = SUM_W'(RELEASE_STEP);
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'(AMP_MAX);

    env_state_e          r_state;
    logic [AMP_W-1:0]    r_amp;
    logic [31:0]         r_audio;

    logic                w_phase;
    logic [SUM_W-1:0]    w_amp_ext;
    logic [SUM_W-1:0]    w_attack_sum;
    logic                w_attack_sat;
    logic                w_release_done;
    logic [AMP_W-1:0]    w_release_diff;
    logic [4:0]          w_vol_scale;
    logic [19:0]         w_product;
    logic [SAMPLE_W-1:0] w_mag;
    logic [SAMPLE_W-1:0] w_sample;

    square_osc u_osc (
        .clk      (clk),
        .rst_n    (rst_n),
        .note_div (note_div),
        .phase    (w_phase)
    );

    assign w_amp_ext      = SUM_W'(r_amp);
    assign w_attack_sum   = w_amp_ext + ATT_V;
    assign w_attack_sat   = (w_attack_sum >= MAX_V);
    assign w_release_done = (w_amp_ext <= REL_V);
    assign w_release_diff = r_amp - REL_V[AMP_W-1:0];

    // Volume 15 maps to a x16 factor so the >>4 leaves full-scale amp untouched.
    assign w_vol_scale = {1'b0, vol} + 5'd1;
    assign w_product   = 20'(r_amp) * 20'(w_vol_scale);
    assign w_mag       = (note_div == '0) ? '0 : w_product[19:4];
    assign w_sample    = w_phase ? w_mag : (SAMPLE_W'(0) - w_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ENV_IDLE;
            r_amp   <= '0;
            r_audio <= '0;
        end else if (sample_tick) begin
            r_audio <= {w_sample, w_sample};
            case (r_state)
                ENV_IDLE: begin
                    r_amp <= '0;
                    if (key_on) r_state <= ENV_ATTACK;
                end
                ENV_ATTACK: begin
                    if (!key_on) begin
                        r_state <= ENV_RELEASE;
                    end else if (w_attack_sat) begin
                        r_amp   <= MAX_V[AMP_W-1:0];
                        r_state <= ENV_SUSTAIN;
                    end else begin
                        r_amp   <= w_attack_sum[AMP_W-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    if (!key_on) r_state <= ENV_RELEASE;
                end
                ENV_RELEASE: begin
                    if (key_on) begin
                        r_state <= ENV_ATTACK;
                    end else if (w_release_done) begin
                        r_amp   <= '0;
                        r_state <= ENV_IDLE;
                    end else begin
                        r_amp   <= w_release_diff;
                    end
                end
                default: r_state <= ENV_IDLE;
            endcase
        end
    end

    assign audio_out = r_audio;
    assign env_state = r_state;
    assign active    = (r_state != ENV_IDLE);

endmodule

// File: tb/tb_tone_sample_gen.sv
// Directed bench for tone_sample_gen: a behavioural oscillator/envelope model
// feeds a scoreboard of expected frames that is drained after each clock.
module tb_tone_sample_gen;

    localparam int ATT    = 4096;
    localparam int REL    = 2048;
    localparam int AMPMAX = 32767;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        key_on = 1'b0;
    logic [19:0] note_div = '0;
    logic [3:0]  vol = '0;
    logic [31:0] audio_out;
    logic        active;
    logic [1:0]  env_state;

    typedef struct {
        logic [31:0] audio;
        logic [1:0]  state;
    } exp_t;

    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;

    int          mCnt = 0;
    bit          mPhase = 1'b0;
    int          mAmp = 0;
    int          mState = 0;
    logic [31:0] mAudio = '0;
    bit          lastPhaseUsed = 1'b0;

    tone_sample_gen #(
        .ATTACK_STEP  (ATT),
        .RELEASE_STEP (REL),
        .AMP_MAX      (AMPMAX)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .key_on      (key_on),
        .note_div    (note_div),
        .vol         (vol),
        .audio_out   (audio_out),
        .active      (active),
        .env_state   (env_state)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s scoreboard empty observed=%h expected=entry", tag, audio_out);
        end else begin
            e = expQ.pop_front();
            checkValue({tag, ".audio"}, audio_out, e.audio);
            checkValue({tag, ".state"}, 32'(env_state), 32'(e.state));
            checkValue({tag, ".active"}, 32'(active), 32'(e.state != 2'd0));
        end
    endtask

    // Called at posedge+1: model the coming edge, push the expectation, clock, then compare.
    task automatic applyStimulus(input bit tick, input string tag);
        int          mag;
        logic [15:0] m16;
        logic [15:0] s16;
        exp_t        e;
        sample_tick = tick;
        if (tick) begin
            mag = (note_div == 0) ? 0 : ((mAmp * (int'(vol) + 1)) >> 4);
            m16 = 16'(mag);
            s16 = mPhase ? m16 : 16'(16'd0 - m16);
            mAudio = {s16, s16};
            lastPhaseUsed = mPhase;
            case (mState)
                0: begin
                    mAmp = 0;
                    if (key_on) mState = 1;
                end
                1: begin
                    if (!key_on) mState = 3;
                    else if (mAmp + ATT >= AMPMAX) begin mAmp = AMPMAX; mState = 2; end
                    else mAmp = mAmp + ATT;
                end
                2: if (!key_on) mState = 3;
                default: begin
                    if (key_on) mState = 1;
                    else if (mAmp - REL <= 0) begin mAmp = 0; mState = 0; end
                    else mAmp = mAmp - REL;
                end
            endcase
        end
        e.audio = mAudio;
        e.state = 2'(mState);
        expQ.push_back(e);
        if (note_div == 0) begin
            mCnt = 0;
            mPhase = 1'b0;
        end else if (mCnt >= int'(note_div) - 1) begin
            mCnt = 0;
            mPhase = ~mPhase;
        end else begin
            mCnt = mCnt + 1;
        end
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        // Reset held from time zero.
        #3;
        checkValue("reset.audio", audio_out, 32'h0);
        checkValue("reset.state", 32'(env_state), 32'h0);
        checkValue("reset.active", 32'(active), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Attack to sustain at full volume, ticks spaced by idle clocks.
        key_on = 1'b1; note_div = 20'd100; vol = 4'd15;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, "attack");
            applyStimulus(1'b0, "attack.hold");
        end
        checkValue("attack.sustain", 32'(env_state), 32'd2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, "sustain.full");

        // Volume 7 scaling and sign against fixed frames.
        vol = 4'd7;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, "vol7");
            checkValue("vol7.const", audio_out, lastPhaseUsed ? 32'h3FFF3FFF : 32'hC001C001);
        end

        // Oscillator at note_div=3, tick every clock to expose phase.
        note_div = 20'd3;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, "osc3");

        // Lower note_div mid-count; counter must wrap on the next clock.
        note_div = 20'd100;
        for (int i = 0; i < 200 && mCnt != 50; i++) applyStimulus(1'b1, "osc100");
        checkValue("osc100.reach", 32'(mCnt), 32'd50);
        note_div = 20'd2;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, "osc.lower");

        // Silence.
        note_div = 20'd0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, "silence");
            checkValue("silence.const", audio_out, 32'h0);
        end

        // Release from sustain down to idle, then one frame of silence.
        note_div = 20'd100; vol = 4'd15; key_on = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, "release");
        checkValue("release.idle", 32'(env_state), 32'd0);
        applyStimulus(1'b1, "release.after");
        checkValue("release.zero", audio_out, 32'h0);

        // Retrigger from release keeps the amplitude.
        key_on = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, "retrig.attack");
        key_on = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, "retrig.release");
        key_on = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, "retrig.again");

        // Asynchronous reset mid-attack.
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("areset.audio", audio_out, 32'h0);
        checkValue("areset.state", 32'(env_state), 32'h0);
        checkValue("areset.active", 32'(active), 32'h0);
        mCnt = 0; mPhase = 1'b0; mAmp = 0; mState = 0; mAudio = '0;
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, "post.reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
